// File: rtl/radix2_divider_pkg.sv
// radix2_divider_pkg: shared operand width and FSM state type for the divider.
package radix2_divider_pkg;
   localparam int OPERAND_WIDTH = 32;
   typedef enum logic [1:0] {IDLE, CALC, FIX, DONE} div_state_t;
endpackage

// File: rtl/radix2_divider.sv
// radix2_divider: iterative radix-2 restoring divider for RV32M DIV/DIVU/REM/REMU.
// Defining RADIX2_DIV_FASTPATH_EN retires |b| > |a| (or a == 0) in one cycle.
module radix2_divider
   import radix2_divider_pkg::*;
#(
   parameter int WIDTH = OPERAND_WIDTH
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic             is_signed,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   output logic             busy,
   output logic             done,
   output logic             valid,
   output logic             dbz,
   output logic [WIDTH-1:0] res,
   output logic [WIDTH-1:0] rem
);
   localparam int CW = $clog2(WIDTH + 1);
   localparam logic [WIDTH-1:0] MIN_NEG = {1'b1, {(WIDTH - 1) {1'b0}}};
   div_state_t state, state_nx;
   logic [WIDTH-1:0] quo, prem, dvs, mag_a, mag_b;
   logic [CW-1:0] cnt;
   logic q_neg, r_neg, dz, ovf, fast, early;
   logic [2*WIDTH-1:0] nxt;
   // Shift {prem, quo} left and trial-subtract; the extra bit exposes the borrow.
   function automatic logic [2*WIDTH-1:0] step(input logic [WIDTH-1:0] pr, q, d);
      logic [WIDTH:0] sh, t;
      sh = {pr, q[WIDTH-1]};
      t = sh - {1'b0, d};
      return t[WIDTH] ? {sh[WIDTH-1:0], q[WIDTH-2:0], 1'b0} : {t[WIDTH-1:0], q[WIDTH-2:0], 1'b1};
   endfunction
   always_comb begin
      mag_a = (is_signed && a[WIDTH-1]) ? -a : a;
      mag_b = (is_signed && b[WIDTH-1]) ? -b : b;
      dz = b == '0;
      ovf = is_signed && a == MIN_NEG && b == '1;
`ifdef RADIX2_DIV_FASTPATH_EN
      fast = mag_b > mag_a || a == '0;
`else
      fast = 1'b0;
`endif
      early = dz || ovf || fast;
      nxt = step(prem, quo, dvs);
   end
   always_ff @(posedge clk or posedge rst)
      if (rst) state <= IDLE;
      else state <= state_nx;
   always_comb begin
      state_nx = state;
      busy = state == CALC || state == FIX;
      done = state == DONE;
      unique case (state)
         IDLE:    state_nx = start ? (early ? DONE : CALC) : IDLE;
         CALC:    state_nx = cnt == CW'(1) ? FIX : CALC;
         FIX:     state_nx = DONE;
         default: state_nx = IDLE;
      endcase
   end
   always_ff @(posedge clk or posedge rst)
      if (rst) begin
         quo <= '0;
         prem <= '0;
         dvs <= '0;
         cnt <= '0;
         q_neg <= 1'b0;
         r_neg <= 1'b0;
         valid <= 1'b0;
         dbz <= 1'b0;
         res <= '0;
         rem <= '0;
      end else
         unique case (state)
            IDLE:
               if (start) begin
                  valid <= early;
                  dbz <= dz;
                  q_neg <= is_signed && (a[WIDTH-1] ^ b[WIDTH-1]);
                  r_neg <= is_signed && a[WIDTH-1];
                  dvs <= mag_b;
                  quo <= mag_a;
                  prem <= '0;
                  cnt <= CW'(WIDTH);
                  if (dz) begin
                     res <= '1;
                     rem <= a;
                  end else if (ovf) begin
                     res <= a;
                     rem <= '0;
                  end else if (fast) begin
                     res <= '0;
                     rem <= a;
                  end
               end
            CALC: begin
               {prem, quo} <= nxt;
               cnt <= cnt - 1'b1;
            end
            FIX: begin
               res <= q_neg ? -quo : quo;
               rem <= r_neg ? -prem : prem;
               valid <= 1'b1;
            end
            default: ;
         endcase
endmodule

// File: tb/tb_radix2_divider.sv
// tb_radix2_divider: directed and random checks of radix2_divider against an arithmetic model.
// Expected latency follows RADIX2_DIV_FASTPATH_EN when it is defined.
module tb_radix2_divider;
   localparam int W = 32;
   logic clk = 1'b0, rst = 1'b1, start = 1'b0, is_signed = 1'b0;
   logic [W-1:0] a = '0, b = '0, res, rem;
   logic busy, done, valid, dbz;
   int checks = 0, failures = 0;
   always #5 clk = ~clk;
   radix2_divider #(.WIDTH(W)) dut (
      .clk(clk), .rst(rst), .start(start), .is_signed(is_signed), .a(a), .b(b),
      .busy(busy), .done(done), .valid(valid), .dbz(dbz), .res(res), .rem(rem)
   );
   task automatic chk(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask
   function automatic logic [W-1:0] mag(input logic [W-1:0] v, input bit s);
      return (s && v[W-1]) ? -v : v;
   endfunction
   function automatic void model(input logic [W-1:0] x, y, input bit s,
                                 output logic [W-1:0] q, r, output int lat);
      int sx, sy;
      sx = int'(x);
      sy = int'(y);
      lat = W + 2;
      if (y == 0) begin
         q = '1; r = x; lat = 1;
      end else if (s && x == 32'h8000_0000 && y == 32'hFFFF_FFFF) begin
         q = x; r = 0; lat = 1;
      end else if (s) begin
         q = W'(sx / sy); r = W'(sx % sy);
      end else begin
         q = x / y; r = x % y;
      end
`ifdef RADIX2_DIV_FASTPATH_EN
      if (y != 0 && lat != 1 && (mag(y, s) > mag(x, s) || x == 0)) lat = 1;
`endif
   endfunction
   // Issues one request; optionally pulses a junk start at cycle "glitch" of the operation.
   task automatic run(input logic [W-1:0] ta, tb_, input bit ts, input int glitch, input string tag);
      logic [W-1:0] eq, er;
      int lat, n;
      model(ta, tb_, ts, eq, er, lat);
      @(negedge clk);
      a = ta; b = tb_; is_signed = ts; start = 1'b1;
      @(posedge clk);
      n = 0;
      do begin
         @(negedge clk);
         n++;
         start = n == glitch;
         if (n == glitch) begin a = ~ta; b = 3; is_signed = ~ts; end
      end while (!done && n < 200);
      start = 1'b0;
      chk({tag, " done"}, W'(done), 1);
      chk({tag, " latency"}, W'(n), W'(lat));
      chk({tag, " res"}, res, eq);
      chk({tag, " rem"}, rem, er);
      chk({tag, " valid"}, W'(valid), 1);
      chk({tag, " dbz"}, W'(dbz), W'(tb_ == 0));
      chk({tag, " busy"}, W'(busy), 0);
      @(negedge clk);
      chk({tag, " done_pulse"}, W'(done), 0);
      chk({tag, " valid_hold"}, W'(valid), 1);
      chk({tag, " res_hold"}, res, eq);
   endtask
   initial begin
      logic [W-1:0] ra, rb;
      int k;
      #1;
      chk("rst busy", W'(busy), 0);
      chk("rst done", W'(done), 0);
      chk("rst valid", W'(valid), 0);
      chk("rst dbz", W'(dbz), 0);
      chk("rst res", res, 0);
      chk("rst rem", rem, 0);
      @(negedge clk);
      rst = 1'b0;
      run(100, 7, 0, 0, "udiv");
      run(32'hFFFF_FFF9, 2, 1, 0, "sdiv_neg_a");
      run(7, 32'hFFFF_FFFE, 1, 0, "sdiv_neg_b");
      run(32'h1234, 0, 0, 0, "dbz_u");
      run(32'h1234, 0, 1, 0, "dbz_s");
      run(32'h8000_0000, 32'hFFFF_FFFF, 1, 0, "sovf");
      run(32'h8000_0000, 32'hFFFF_FFFF, 0, 0, "u_minneg");
      run(32'h8000_0000, 1, 1, 0, "s_minneg_by1");
      run(5, 9, 0, 0, "small_a");
      run(0, 5, 1, 0, "zero_a");
      run(1000, 3, 0, 5, "start_in_calc");
      // Reset in the middle of CALC must discard the operation at once.
      @(negedge clk);
      a = 1000; b = 7; is_signed = 1'b0; start = 1'b1;
      @(posedge clk);
      @(negedge clk);
      start = 1'b0;
      repeat (9) @(negedge clk);
      chk("mid busy", W'(busy), 1);
      rst = 1'b1;
      #1;
      chk("mid_rst busy", W'(busy), 0);
      chk("mid_rst done", W'(done), 0);
      chk("mid_rst valid", W'(valid), 0);
      chk("mid_rst dbz", W'(dbz), 0);
      chk("mid_rst res", res, 0);
      chk("mid_rst rem", rem, 0);
      @(negedge clk);
      rst = 1'b0;
      run(9, 3, 0, 0, "after_rst");
      for (int i = 0; i < 40; i++) begin
         ra = $urandom;
         if ($urandom_range(0, 3) == 0) ra = W'($urandom_range(0, 50));
         k = $urandom_range(0, 4);
         rb = k == 0 ? '0 : k == 1 ? W'($urandom_range(1, 20)) :
              k == 2 ? -W'($urandom_range(1, 20)) : W'($urandom);
         run(ra, rb, 1'($urandom_range(0, 1)), 0, $sformatf("rnd%0d", i));
      end
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
